mult_control_unit: RTL and testbench

- Sequencer for the 8x8 signed add-shift multiplier.
- Sits directly upstream of the A/B shift registers and the X sign flip-flop, and drives their clear, load and shift-enable inputs.
- Also steers the 9-bit adder between add and subtract based on multiplier bit M (= B[0]).
- One multiply = clear A/X, then N_BITS iterations of (conditional add or subtract, shift).

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_control_unit.sv | 86 ++++++++
 tb/tb_mult_control_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the signed add-shift multiplier control path.
package mult_pkg;

   localparam int MULT_BITS = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      ADD   = 3'd2,
      SHIFT = 3'd3,
      HOLD  = 3'd4
   } ctrl_state_t;

endpackage

// File: rtl/mult_control_unit.sv
// Sequencer for the 8x8 signed add-shift multiplier: drives clear/load/add/sub/shift
// strobes of the A/B/X datapath and flags completion until Run is released.
module mult_control_unit
   import mult_pkg::*;
#(
   parameter int N_BITS = MULT_BITS,
   parameter int CNT_W  = $clog2(N_BITS)
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Run,
   input  logic ClearA_LoadB,
   input  logic M,
   output logic clr_ld,
   output logic clear_AX,
   output logic add_en,
   output logic sub_en,
   output logic shift_en,
   output logic done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

   ctrl_state_t state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_ld    = 1'b0;
      clear_AX  = 1'b0;
      add_en    = 1'b0;
      sub_en    = 1'b0;
      shift_en  = 1'b0;
      done      = 1'b0;

      unique case (state)
         IDLE: begin
            // Load takes precedence over start; Run is looked at again next cycle.
            if (ClearA_LoadB)
               clr_ld = 1'b1;
            else if (Run)
               state_nxt = CLR;
         end
         CLR: begin
            clear_AX  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ADD;
         end
         ADD: begin
            // Last partial product carries negative weight in two's complement.
            if (M && (cnt == LAST))
               sub_en = 1'b1;
            else if (M)
               add_en = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (cnt == LAST)
               state_nxt = HOLD;
            else begin
               cnt_nxt   = cnt + CNT_W'(1);
               state_nxt = ADD;
            end
         end
         HOLD: begin
            done = 1'b1;
            if (!Run)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mult_control_unit.sv
// Bench for mult_control_unit: wraps it with a behavioural A/B/X shift-register and
// 9-bit adder datapath and checks strobe timing and signed products.
module tb_mult_control_unit;

   logic Clk = 1'b0;
   logic Reset_n, Run, ClearA_LoadB, M;
   logic clr_ld, clear_AX, add_en, sub_en, shift_en, done;

   logic [7:0] A = 8'h00, B = 8'h00, S = 8'h00, sw = 8'h00;
   logic       X = 1'b0;
   logic       use_dp = 1'b0, m_drv = 1'b0;

   int total = 0;
   int bad   = 0;

   mult_control_unit dut (
      .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
      .clr_ld(clr_ld), .clear_AX(clear_AX), .add_en(add_en), .sub_en(sub_en),
      .shift_en(shift_en), .done(done)
   );

   always #5 Clk = ~Clk;

   assign M = use_dp ? B[0] : m_drv;

   // Existing datapath: A/B shift registers, X sign flop and 9-bit adder.
   always @(posedge Clk) begin
      if (clr_ld) begin
         A <= 8'h00; X <= 1'b0; B <= sw;
      end else if (clear_AX) begin
         A <= 8'h00; X <= 1'b0;
      end else if (add_en) begin
         {X, A} <= {A[7], A} + {S[7], S};
      end else if (sub_en) begin
         {X, A} <= {A[7], A} - {S[7], S};
      end else if (shift_en) begin
         A <= {X, A[7:1]};
         B <= {A[0], B[7:1]};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   function automatic logic [5:0] outs();
      return {clr_ld, clear_AX, add_en, sub_en, shift_en, done};
   endfunction

   // Expected strobes k cycles after Run was sampled, multiplier bits bval.
   function automatic logic [5:0] sched(input int k, input logic [7:0] bval);
      logic ce, ae, se, sh, dn;
      ce = (k == 1);
      ae = (k >= 2) && (k <= 14) && (k % 2 == 0) && bval[(k - 2) / 2];
      se = (k == 16) && bval[7];
      sh = (k >= 3) && (k <= 17) && (k % 2 == 1);
      dn = (k >= 18);
      return {1'b0, ce, ae, se, sh, dn};
   endfunction

   task automatic step();
      @(posedge Clk); #1;
   endtask

   task automatic load_b(input logic [7:0] b);
      sw = b;
      ClearA_LoadB = 1'b1;
      @(negedge Clk);
      total++;
      if (outs() !== 6'b100000) begin
         bad++;
         $display("FAIL load_b outs got=%b want=%b", outs(), 6'b100000);
      end
      step();
      ClearA_LoadB = 1'b0;
   endtask

   // One Run press; optional ClearA_LoadB at cycle cl_at and random Run noise.
   task automatic mult_seq(input logic [7:0] s, input logic [7:0] bval, input bit chk_prod,
                           input int cl_at, input bit noise, input string name);
      int p;
      S = s;
      Run = 1'b1;
      step();
      for (int k = 1; k <= 18; k++) begin
         Run = (noise && k <= 17) ? 1'($urandom_range(0, 1)) : 1'b0;
         ClearA_LoadB = (k == cl_at);
         @(negedge Clk);
         total++;
         if (outs() !== sched(k, bval)) begin
            bad++;
            $display("FAIL %s cycle+%0d outs got=%b want=%b", name, k, outs(), sched(k, bval));
         end
         step();
      end
      ClearA_LoadB = 1'b0;
      @(negedge Clk);
      total++;
      if (outs() !== 6'b000000) begin
         bad++;
         $display("FAIL %s idle_after outs got=%b want=000000", name, outs());
      end
      if (chk_prod) begin
         p = $signed(s) * $signed(bval);
         total++;
         if ({A, B} !== p[15:0]) begin
            bad++;
            $display("FAIL %s product s=%h b=%h got=%h want=%h", name, s, bval, {A, B}, p[15:0]);
         end
      end
      step();
   endtask

   task automatic test_reset();
      use_dp = 1'b0; m_drv = 1'b1;
      Reset_n = 1'b0; Run = 1'b0; ClearA_LoadB = 1'b0;
      step(); step();
      Reset_n = 1'b1;
      @(negedge Clk);
      total++;
      if (outs() !== 6'b000000) begin
         bad++;
         $display("FAIL reset_state outs got=%b want=000000", outs());
      end
      step();
      Run = 1'b1;
      step();
      Run = 1'b0;
      for (int k = 1; k < 8; k++) step();
      // Now in the ADD cycle with cnt=3.
      @(negedge Clk);
      total++;
      if (outs() !== 6'b001000) begin
         bad++;
         $display("FAIL reset_midadd pre outs got=%b want=001000", outs());
      end
      step();
      Reset_n = 1'b0;
      step(); step();
      Reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         total++;
         if (outs() !== 6'b000000) begin
            bad++;
            $display("FAIL reset_midadd after%0d outs got=%b want=000000", k, outs());
         end
         step();
      end
      use_dp = 1'b1;
      load_b(8'h03);
      mult_seq(8'h07, 8'h03, 1'b1, -1, 1'b0, "reset_rerun");
   endtask

   task automatic test_m_high();
      use_dp = 1'b0; m_drv = 1'b1;
      mult_seq(8'h11, 8'hFF, 1'b0, -1, 1'b0, "m_high");
      use_dp = 1'b1;
   endtask

   task automatic test_vectors();
      use_dp = 1'b1;
      load_b(8'h03);
      mult_seq(8'h07, 8'h03, 1'b1, -1, 1'b0, "v_7x3");
      total++;
      if (X !== 1'b0) begin
         bad++;
         $display("FAIL v_7x3 X got=%b want=0", X);
      end
      load_b(8'h03);
      mult_seq(8'hFE, 8'h03, 1'b1, -1, 1'b0, "v_m2x3");
      load_b(8'hFE);
      mult_seq(8'h03, 8'hFE, 1'b1, -1, 1'b0, "v_3xm2");
      load_b(8'h80);
      mult_seq(8'h80, 8'h80, 1'b1, -1, 1'b0, "v_80x80");
   endtask

   task automatic test_random();
      logic [7:0] s, b;
      use_dp = 1'b1;
      for (int i = 0; i < 16; i++) begin
         s = 8'($urandom);
         b = 8'($urandom);
         load_b(b);
         mult_seq(s, b, 1'b1, -1, 1'b1, "random");
      end
   endtask

   task automatic test_run_held();
      int clr_cnt;
      bit done_ok;
      int p;
      use_dp = 1'b1;
      load_b(8'h05);
      S = 8'h03;
      Run = 1'b1;
      clr_cnt = 0;
      done_ok = 1'b1;
      step();
      for (int k = 1; k <= 40; k++) begin
         @(negedge Clk);
         if (clear_AX === 1'b1) clr_cnt++;
         if (k >= 18 && done !== 1'b1) done_ok = 1'b0;
         step();
      end
      total++;
      if (clr_cnt != 1) begin
         bad++;
         $display("FAIL run_held clear_count got=%0d want=1", clr_cnt);
      end
      total++;
      if (!done_ok) begin
         bad++;
         $display("FAIL run_held done_stays got=0 want=1");
      end
      Run = 1'b0;
      step();
      @(negedge Clk);
      total++;
      if (outs() !== 6'b000000) begin
         bad++;
         $display("FAIL run_held release outs got=%b want=000000", outs());
      end
      p = 3 * 5;
      total++;
      if ({A, B} !== p[15:0]) begin
         bad++;
         $display("FAIL run_held product got=%h want=%h", {A, B}, p[15:0]);
      end
      step();
      // B keeps the previous low byte; a new press multiplies it by the new S.
      mult_seq(8'h02, 8'h0F, 1'b1, -1, 1'b0, "retained_b");
   endtask

   task automatic test_priority();
      use_dp = 1'b1;
      sw = 8'h06;
      Run = 1'b1;
      ClearA_LoadB = 1'b1;
      @(negedge Clk);
      total++;
      if (outs() !== 6'b100000) begin
         bad++;
         $display("FAIL prio both outs got=%b want=100000", outs());
      end
      step();
      Run = 1'b0;
      ClearA_LoadB = 1'b0;
      @(negedge Clk);
      total++;
      if (outs() !== 6'b000000) begin
         bad++;
         $display("FAIL prio no_clr outs got=%b want=000000", outs());
      end
      step();
      // Load during SHIFT (cycle +5) must be ignored.
      mult_seq(8'hF9, 8'h06, 1'b1, 5, 1'b0, "load_in_shift");
   endtask

   initial begin
      Reset_n = 1'b0; Run = 1'b0; ClearA_LoadB = 1'b0;
      test_reset();
      test_m_high();
      test_vectors();
      test_run_held();
      test_priority();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
